wbu_regfile_queued: RTL
=======================

Name: wbu_regfile_queued

Overview:
- Parametrised write-back unit plus integer register file; next generation of the single-entry two-cycle IDLE/WRITE WBU.
- Accepts LSU results through a valid/ready handshake into a DEPTH-entry in-order retire queue, and retires one entry per cycle into the register file.
- Serves NRD combinational read ports to IDU, bypassing from younger queued writes, so back-to-back dependent instructions need no stall.
- Adds retire stall, configurable register count (RV32E/RV32I) and a 64-bit retired-instruction counter.

Parameters:
- DATA_WIDTH, 32, register and write-data width.
- NREG, 16, architectural registers (16 or 32); AW = clog2(NREG) address bits used.
- NRD, 2, number of read ports.
- DEPTH, 2, retire queue entries (1..4).
- PC_RESET, 32'h7FFFFFFC, reset value of pc.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  LSU result valid.
- in_ready  out  1  queue can accept.
- in_inst  in  32  instruction word; rd=[11:7], opcode=[6:0].
- in_wdata  in  DATA_WIDTH  write-back value.
- in_pc  in  32  next pc of the instruction.
- in_num  in  64  instruction sequence number.
- retire_stall  in  1  hold head entry (sim/difftest backpressure).
- raddr  in  NRD*5  read addresses, port k at [5k+4:5k].
- rdata  out  NRD*DATA_WIDTH  read data, port k at [DATA_WIDTH*k +: DATA_WIDTH].
- pc  out  32  pc of last retired instruction.
- instr_completed  out  1  one-cycle pulse per retirement.
- retire_num  out  64  in_num of last retired instruction.
- retire_count  out  64  total retirements since reset.
- pend_count  out  clog2(DEPTH+1)  queued entries.

Behaviour:
- Reset: synchronous, active-high on clock. Queue emptied without retiring. pc=PC_RESET. instr_completed=0, retire_num=0, retire_count=0, pend_count=0. All RF entries =0.
- wen decode: wen=1 iff opcode is one of 0010011, 0110111, 0010111, 1110011, 1101111, 1100111, 0110011, 0000011.
- Register index: rd[AW-1:0]; upper address bits ignored. Index 0 is never written.
- Accept: at the edge with in_valid&&in_ready, entry {inst, wdata, pc, num, wen} is appended at the tail.
- in_ready = (pend_count<DEPTH) || !retire_stall. When full, a same-cycle retire frees the slot; simultaneous accept and retire keeps pend_count unchanged.
- Retire:
  - Each edge where pend_count>0 and !retire_stall, the head entry pops.
  - If wen and index!=0, RF[index] is written.
  - pc, retire_num and retire_count are updated; instr_completed=1 for exactly that following cycle, otherwise 0.
- Latency: accepted at edge T into an empty queue with no stall -> retires at edge T+1 (RF visible, pulse high, during cycle T+1). Sustained throughput 1 per cycle.
- Read ports:
  - Purely combinational.
  - Address index 0 -> 0.
  - Otherwise, the youngest queued entry with wen and matching index wins; if none, RF.
  - Entries accepted in the current cycle are not visible until the next cycle.
- retire_count wraps modulo 2^64.
- Retire order is strictly FIFO; wrap of the internal head/tail pointers is invisible externally.
- reset asserted mid-operation: queued entries are discarded; RF is cleared the same edge.

Test Plan:
- Reset, then read raddr=5 on both ports -> rdata=0; pc=7FFFFFFC; retire_count=0; in_ready=1.
- Accept addi x5 (inst 00500293, wdata=5, pc=80000004, num=1) -> next cycle instr_completed=1, pc=80000004, retire_num=1, rdata(x5)=5, retire_count=1.
- retire_stall=1; push x6=A then x6=B (DEPTH=2):
  - Required: in_ready=0 after two accepts; rdata(x6)=B (youngest bypass).
  - Release stall -> two consecutive pulses, in order num 2 then 3; final RF x6=B.
- Store (opcode 0100011) with rd field=7, wdata=FFFF -> retires (pulse, count+1) but x7 unchanged.
- NREG=16: write rd=17 with wdata=9 -> x1=9; write rd=0 -> x0 still reads 0.
- Full queue with retire_stall=0 and in_valid=1 continuously for 10 cycles -> in_ready stays 1, 10 pulses on consecutive cycles, retire_count=10; assert reset mid-stream -> pend_count=0, no further pulses.

Source files
------------

// File: rtl/wbu_regfile_queued.sv
// Write-back unit with an in-order retire queue and an integer register file.
// Read ports bypass from queued writes so dependent instructions never stall.
module wbu_regfile_queued #(
    parameter int          DATA_WIDTH = 32,
    parameter int          NREG       = 16,
    parameter int          NRD        = 2,
    parameter int          DEPTH      = 2,
    parameter logic [31:0] PC_RESET   = 32'h7FFFFFFC
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [31:0]                   in_inst,
    input  logic [DATA_WIDTH-1:0]         in_wdata,
    input  logic [31:0]                   in_pc,
    input  logic [63:0]                   in_num,
    input  logic                          retire_stall,
    input  logic [NRD*5-1:0]              raddr,
    output logic [NRD*DATA_WIDTH-1:0]     rdata,
    output logic [31:0]                   pc,
    output logic                          instr_completed,
    output logic [63:0]                   retire_num,
    output logic [63:0]                   retire_count,
    output logic [$clog2(DEPTH+1)-1:0]    pend_count
);

    localparam int            AW      = $clog2(NREG);
    localparam int            CW      = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic                  wen;
        logic [AW-1:0]         idx;
        logic [DATA_WIDTH-1:0] wdata;
        logic [31:0]           pc;
        logic [63:0]           num;
    } entry_t;

    function automatic logic dec_wen(input logic [6:0] op);
        case (op)
            7'b0010011, 7'b0110111, 7'b0010111, 7'b1110011,
            7'b1101111, 7'b1100111, 7'b0110011, 7'b0000011: dec_wen = 1'b1;
            default:                                         dec_wen = 1'b0;
        endcase
    endfunction

    // Queue is a shift register: slot 0 is always the oldest entry.
    entry_t                q_q [DEPTH];
    entry_t                q_d [DEPTH];
    entry_t                in_entry;
    logic [CW-1:0]         count_q, count_d, wr_pos;
    logic                  push, pop;
    logic [DATA_WIDTH-1:0] rf_q [NREG];
    logic [31:0]           pc_q;
    logic                  completed_q;
    logic [63:0]           retire_num_q, retire_count_q;

    // Only the opcode, rd index and low address bits matter; the rest is deliberately dropped.
    logic unused_bits;
    assign unused_bits = ^{in_inst, raddr};

    assign pop      = (count_q != '0) && !retire_stall;
    assign in_ready = (count_q < DEPTH_C) || !retire_stall;
    assign push     = in_valid && in_ready;
    assign wr_pos   = count_q - CW'(pop);
    assign in_entry = '{wen: dec_wen(in_inst[6:0]), idx: in_inst[7 +: AW],
                        wdata: in_wdata, pc: in_pc, num: in_num};

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
        q_d     = q_q;
        count_d = count_q + CW'(push) - CW'(pop);
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) q_d[i] = q_q[i+1];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (push && wr_pos == CW'(i)) q_d[i] = in_entry;
        end
    end

    // Payload is qualified by count_q, so it needs no reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        q_q <= q_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q        <= '0;
            pc_q           <= PC_RESET;
            completed_q    <= 1'b0;
            retire_num_q   <= '0;
            retire_count_q <= '0;
            // NOTE: the register file is architecturally zeroed on reset, so this memory is reset explicitly.
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            count_q     <= count_d;
            completed_q <= pop;
            if (pop) begin
                if (q_q[0].wen && q_q[0].idx != '0) rf_q[q_q[0].idx] <= q_q[0].wdata;
                pc_q           <= q_q[0].pc;
                retire_num_q   <= q_q[0].num;
                retire_count_q <= retire_count_q + 64'd1;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]         ridx;
        logic [DATA_WIDTH-1:0] rval;
        assign ridx = raddr[5*k +: AW];
        // Later slots are younger, so the last match wins.
        always_comb begin
            rval = rf_q[ridx];
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) < count_q && q_q[i].wen && q_q[i].idx == ridx) rval = q_q[i].wdata;
            end
            if (ridx == '0) rval = '0;
        end
        assign rdata[DATA_WIDTH*k +: DATA_WIDTH] = rval;
    end

    assign pc              = pc_q;
    assign instr_completed = completed_q;
    assign retire_num      = retire_num_q;
    assign retire_count    = retire_count_q;
    assign pend_count      = count_q;

endmodule
